// File: rtl/select_action_pkg.sv
// Shared types and defaults for the multi-candidate action selector.
// The explore path is compiled in only when SELECT_EXPLORE_EN is defined.
package select_action_pkg;

    typedef enum logic [2:0] {
        WAIT_EN    = 3'd0,
        WAIT_START = 3'd1,
        SCAN       = 3'd2,
        DECIDE     = 3'd3,
        WR_ACT     = 3'd4,
        WR_FLAG    = 3'd5,
        DONE_S     = 3'd6
    } state_t;

    localparam logic [15:0] SELF_ID_DEF     = 16'd65;
    localparam logic [10:0] FLAG_ADDR_DEF   = 11'h2;
    localparam logic [10:0] ACTION_ADDR_DEF = 11'h3;

    // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/select_action_multi_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR feeding the explore decision.
// Only instantiated when SELECT_EXPLORE_EN is defined.
module lfsr16
    import select_action_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    output logic [15:0] value
);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) value <= LFSR_SEED;
        else     value <= lfsr_next(value);
    end

endmodule

// File: rtl/select_action_multi.sv
// Scans NUM_CAND candidate hops for the best valid Q-value, applies the sink
// override and writes the action/flag to node memory. Macro: SELECT_EXPLORE_EN.
module select_action_multi
    import select_action_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 16,
    parameter int                    NUM_CAND    = 4,
    parameter int                    ADDR_WIDTH  = 11,
    parameter logic [WORD_WIDTH-1:0] SELF_ID     = WORD_WIDTH'(SELF_ID_DEF),
    parameter logic [ADDR_WIDTH-1:0] FLAG_ADDR   = ADDR_WIDTH'(FLAG_ADDR_DEF),
    parameter logic [ADDR_WIDTH-1:0] ACTION_ADDR = ADDR_WIDTH'(ACTION_ADDR_DEF)
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           start,
    input  logic [NUM_CAND-1:0]            cand_valid,
    input  logic [NUM_CAND*WORD_WIDTH-1:0] cand_id,
    input  logic [NUM_CAND*WORD_WIDTH-1:0] cand_q,
    input  logic [WORD_WIDTH-1:0]          nextsink,
    input  logic [7:0]                     explore_thresh,
    output logic                           wr_en,
    output logic [ADDR_WIDTH-1:0]          address,
    output logic [WORD_WIDTH-1:0]          data_out,
    output logic [WORD_WIDTH-1:0]          action,
    output logic [3:0]                     best_idx,
    output logic                           forAggregation,
    output logic                           explored,
    output logic                           done,
    output logic [2:0]                     state_dbg
);

    localparam int                    VW       = NUM_CAND * WORD_WIDTH;
    localparam logic [3:0]            LAST_IDX = 4'(NUM_CAND - 1);
    localparam logic [WORD_WIDTH-1:0] Q_MIN    = {1'b1, {(WORD_WIDTH-1){1'b0}}};

    state_t state, state_next;

    logic [NUM_CAND-1:0]   cap_valid;
    logic [VW-1:0]         cap_id, cap_q;
    logic [WORD_WIDTH-1:0] cap_sink;

    logic [3:0]            scan_idx, best_sel;
    logic [WORD_WIDTH-1:0] best_q, best_id;
    logic                  best_found;

    logic [VW-1:0]         id_shift, q_shift;
    logic [NUM_CAND-1:0]   valid_shift;
    logic                  cur_valid;
    logic [WORD_WIDTH-1:0] cur_id, cur_q;

    logic [WORD_WIDTH-1:0] dec_action;
    logic [3:0]            dec_idx;
    logic                  dec_expl;

    assign state_dbg = state;

`ifdef SELECT_EXPLORE_EN
    logic [15:0]         lfsr_value;
    logic [7:0]          cap_thresh;
    logic [3:0]          exp_idx;
    logic                exp_take, exp_valid;
    logic [VW-1:0]       exp_id_shift;
    logic [NUM_CAND-1:0] exp_valid_shift;
    logic                unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clock (clock),
        .rst   (rst),
        .value (lfsr_value)
    );

    assign unused_lfsr_hi = ^lfsr_value[15:12];

    always_comb begin
        exp_idx         = 4'(32'(lfsr_value[11:8]) % NUM_CAND);
        exp_take        = lfsr_value[7:0] < cap_thresh;
        exp_valid_shift = cap_valid >> exp_idx;
        exp_valid       = exp_valid_shift[0];
        exp_id_shift    = cap_id >> (32'(exp_idx) * WORD_WIDTH);
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^explore_thresh;
`endif

    // Candidate under inspection this SCAN cycle.
    always_comb begin
        id_shift    = cap_id >> (32'(scan_idx) * WORD_WIDTH);
        q_shift     = cap_q >> (32'(scan_idx) * WORD_WIDTH);
        valid_shift = cap_valid >> scan_idx;
        cur_id      = id_shift[WORD_WIDTH-1:0];
        cur_q       = q_shift[WORD_WIDTH-1:0];
        cur_valid   = valid_shift[0];
    end

    // Decision priority: empty set, explore, greedy; the sink override wins last.
    always_comb begin
        dec_action = best_id;
        dec_idx    = best_sel;
        dec_expl   = 1'b0;
        if (!best_found) begin
            dec_action = SELF_ID;
            dec_idx    = 4'd0;
        end
`ifdef SELECT_EXPLORE_EN
        else if (exp_take && exp_valid) begin
            dec_action = exp_id_shift[WORD_WIDTH-1:0];
            dec_idx    = exp_idx;
            dec_expl   = 1'b1;
        end
`endif
        if (cap_sink != SELF_ID) begin
            dec_action = cap_sink;
            dec_expl   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= WAIT_EN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_EN:    if (en) state_next = WAIT_START;
            WAIT_START: if (start) state_next = SCAN;
            SCAN:       if (scan_idx == LAST_IDX) state_next = DECIDE;
            DECIDE:     state_next = WR_ACT;
            WR_ACT:     state_next = (action == SELF_ID) ? WR_FLAG : DONE_S;
            WR_FLAG:    state_next = DONE_S;
            DONE_S:     state_next = WAIT_EN;
            default:    state_next = WAIT_EN;
        endcase
    end

    // Registered outputs reflect the state being executed on this edge.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_en          <= 1'b0;
            address        <= '0;
            data_out       <= '0;
            action         <= '0;
            best_idx       <= '0;
            forAggregation <= 1'b0;
            explored       <= 1'b0;
            done           <= 1'b0;
            cap_valid      <= '0;
            cap_id         <= '0;
            cap_q          <= '0;
            cap_sink       <= '0;
            scan_idx       <= '0;
            best_sel       <= '0;
            best_q         <= Q_MIN;
            best_id        <= '0;
            best_found     <= 1'b0;
`ifdef SELECT_EXPLORE_EN
            cap_thresh     <= '0;
`endif
        end else begin
            case (state)
                WAIT_EN: begin
                    if (en) begin
                        action         <= '0;
                        best_idx       <= '0;
                        forAggregation <= 1'b0;
                        explored       <= 1'b0;
                        done           <= 1'b0;
                        wr_en          <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (start) begin
                        cap_valid  <= cand_valid;
                        cap_id     <= cand_id;
                        cap_q      <= cand_q;
                        cap_sink   <= nextsink;
                        scan_idx   <= '0;
                        best_sel   <= '0;
                        best_q     <= Q_MIN;
                        best_id    <= '0;
                        best_found <= 1'b0;
`ifdef SELECT_EXPLORE_EN
                        cap_thresh <= explore_thresh;
`endif
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (cur_valid && (!best_found || ($signed(cur_q) > $signed(best_q)))) begin
                        best_found <= 1'b1;
                        best_q     <= cur_q;
                        best_id    <= cur_id;
                        best_sel   <= scan_idx;
                    end
                    scan_idx <= (scan_idx == LAST_IDX) ? 4'd0 : scan_idx + 4'd1;
                end
                DECIDE: begin
                    action   <= dec_action;
                    best_idx <= dec_idx;
                    explored <= dec_expl;
                end
                WR_ACT: begin
                    wr_en    <= 1'b1;
                    address  <= ACTION_ADDR;
                    data_out <= action;
                    if (action == SELF_ID) forAggregation <= 1'b1;
                end
                WR_FLAG: begin
                    wr_en    <= 1'b1;
                    address  <= FLAG_ADDR;
                    data_out <= WORD_WIDTH'(1);
                end
                DONE_S: begin
                    wr_en <= 1'b0;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
